multi_bank_regfile: RTL and testbench
=====================================

# multi_bank_regfile

Parametrised register-bank DUT for the register-layer regression benches: NUM_BANKS independent banks of NUM_REGS registers behind one shared request/acknowledge bus. It generalises the single-bank, fixed-width register DUT with configurable data width and bank count, and adds several new behaviours:
- a read-only ID register per bank;
- a saturating hardware-event counter per bank;
- address/access error reporting;
- a reverse-reset mode that loads inverted reset values.

It sits directly under the bench top, driven by the UVC interface.

## Interface
- NUM_BANKS, 1: number of banks (1..16).
- NUM_REGS, 10: registers per bank (3..256).
- DATA_W, 32: register and bus data width (8..64, multiple of 8).
- RESET_VAL, 32'h0: reset value of every RW register, truncated or zero-extended to DATA_W.
- clk  in  1  single clock; everything is synchronous to its rising edge.
- reset  in  1  synchronous, active-high reset.
- reverse_reset  in  1  qualifies reset; when 1 during reset, RW registers load ~RESET_VAL.
- req  in  1  access request.
- wr  in  1  1 = write, 0 = read; sampled with req.
- bank  in  max(1,$clog2(NUM_BANKS))  bank select.
- addr  in  $clog2(NUM_REGS)  register index.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables for writes.
- hw_event  in  NUM_BANKS  per-bank event pulse, one bit per bank.
- ack  out  1  one-cycle access completion.
- err  out  1  error flag, valid only with ack.
- rdata  out  DATA_W  read data, valid only with ack.

## Operation
- Register map per bank:
  - addr 0 = ID (RO): reads the bank index, zero-extended.
  - addr 1..NUM_REGS-2 = RW.
  - addr NUM_REGS-1 = EVT (event counter).
- RW write: byte lane i updates only when be[i]=1. A write with be=0 is legal, completes with ack, and changes nothing.
- EVT counter:
  - Increments by 1 on each cycle with hw_event[b]=1.
  - Saturates at all-ones.
  - Any write to EVT clears it, regardless of be.
  - A clearing write and hw_event in the same cycle leave EVT=1.
- Errors: err=1 with ack, no state change, rdata=0 when:
  - bank >= NUM_BANKS;
  - addr >= NUM_REGS;
  - a write targets ID.
- Reads of any valid address complete with err=0.
- FSM states: IDLE and RESP.
  - IDLE: if req=1, sample wr/bank/addr/wdata/be, perform the write or capture read data, then go to RESP.
  - RESP: assert ack, err and rdata for one cycle; req is ignored; go to IDLE.
- Reset values:
  - ack=0, err=0, rdata=0, state IDLE.
  - RW registers = RESET_VAL, or ~RESET_VAL when reverse_reset=1.
  - EVT = 0 in both modes.
  - ID is constant.
- Reset mid-transaction: the transaction is discarded and no write lands. The cycle after reset shows ack=0 and state IDLE.
- hw_event is ignored while reset=1.

## Timing
- A request accepted in IDLE at cycle N gives ack, err and rdata in cycle N+1.
- A write is visible to a read accepted at N+2 or later.
- Maximum throughput is one access per two cycles. Holding req high issues back-to-back accesses at N, N+2, N+4, …
- rdata, err and ack are registered outputs; there is no combinational path from req to outputs.
- An EVT read returns the counter value as of the request cycle: it excludes an event in that same cycle and includes all earlier events.

## Structure
- Shared package regfile_pkg, containing:
  - enum acc_kind_e {ACC_ID, ACC_RW, ACC_EVT};
  - enum state_e {IDLE, RESP};
  - function reg_kind(addr, NUM_REGS) returning acc_kind_e;
  - localparam constants for the minimum and maximum parameter bounds.
- Sub-module regfile_bank:
  - One register bank with its ID, RW and EVT registers and byte-enable write logic.
  - Instantiated NUM_BANKS times via generate.
- The top level owns the FSM, address decode, error logic and read mux.

## Test plan
- Reset values: reset with reverse_reset=0, RESET_VAL=32'hA5A5_0000, NUM_BANKS=4, then read bank 2 addr 1 and addr 0 -> rdata 32'hA5A5_0000 and 32'h2, err=0. Repeat with reverse_reset=1 -> addr 1 reads 32'h5A5A_FFFF.
- Byte enables: write 32'h1122_3344 with be=4'b0101 to bank 1 addr 3 (previous value 0) -> read returns 32'h0022_0044; ack exactly one cycle after req each time.
- Event counter: DATA_W=8, hold hw_event[0]=1 for 300 cycles -> bank 0 EVT reads 8'hFF. Write EVT while hw_event[0]=1 -> the next read, after a further idle cycle without events, returns 8'h01.
- Errors:
  - bank=5 with NUM_BANKS=4 -> ack, err=1, rdata=0.
  - addr=10 with NUM_REGS=10 -> ack, err=1, rdata=0.
  - Write 32'hFFFF_FFFF to ID -> err=1, and a later ID read still returns the bank index.
- Back-to-back and reset abort:
  - req held high over 6 cycles -> 3 acks at cycles 1, 3, 5.
  - Assert reset in the RESP cycle of a write -> no ack on the next cycle, and the register reads its reset value.

Source files
------------

// File: rtl/multi_bank_regfile_pkg.sv
// Shared types and helpers for the multi-bank register file.
// Holds access kinds, FSM states, parameter bounds and the address classifier.
package regfile_pkg;

    localparam int MIN_BANKS  = 1;
    localparam int MAX_BANKS  = 16;
    localparam int MIN_REGS   = 3;
    localparam int MAX_REGS   = 256;
    localparam int MIN_DATA_W = 8;
    localparam int MAX_DATA_W = 64;

    typedef enum logic [1:0] {
        ACC_ID,
        ACC_RW,
        ACC_EVT
    } acc_kind_e;

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    // Out-of-range addresses classify as RW; the caller flags them separately.
    function automatic acc_kind_e reg_kind(input int addr, input int num_regs);
        if (addr == 0) begin
            return ACC_ID;
        end
        if (addr == num_regs - 1) begin
            return ACC_EVT;
        end
        return ACC_RW;
    endfunction

endpackage

// File: rtl/multi_bank_regfile_if.sv
// Request/acknowledge bus of the multi-bank register file.
// master drives req/wr/bank/addr/wdata/be; slave returns ack/err/rdata.
interface multi_bank_regfile_if #(
    parameter int NUM_BANKS = 1,
    parameter int NUM_REGS  = 10,
    parameter int DATA_W    = 32
) ();

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                  req;
    logic                  wr;
    logic [BANK_W-1:0]     bank;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  ack;
    logic                  err;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, bank, addr, wdata, be,
        input  ack, err, rdata
    );

    modport slave (
        input  req, wr, bank, addr, wdata, be,
        output ack, err, rdata
    );

endinterface

// File: rtl/multi_bank_regfile_bank.sv
// One register bank: constant ID, byte-enabled RW registers, saturating EVT.
// Ports: clk, reset, reverse_reset, we, addr, wdata, be, hw_event in; rdata out.
module regfile_bank #(
    parameter int          BANK_IDX  = 0,
    parameter int          NUM_REGS  = 10,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        reverse_reset,
    input  logic                        we,
    input  logic [$clog2(NUM_REGS)-1:0] addr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [DATA_W/8-1:0]         be,
    input  logic                        hw_event,
    output logic [DATA_W-1:0]           rdata
);

    import regfile_pkg::*;

    localparam int              NUM_RW = NUM_REGS - 2;
    localparam logic [DATA_W-1:0] RST_V = DATA_W'(RESET_VAL);
    localparam logic [DATA_W-1:0] ONE   = DATA_W'(1);

    logic [DATA_W-1:0] rw_q [NUM_RW];
    logic [DATA_W-1:0] evt_q;
    acc_kind_e         kind;

    assign kind = reg_kind(int'(addr), NUM_REGS);

    // RW entry i lives at address i+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= reverse_reset ? ~RST_V : RST_V;
            end
        end else if (we && kind == ACC_RW) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (int'(addr) == i + 1) begin
                    for (int j = 0; j < DATA_W / 8; j++) begin
                        if (be[j]) begin
                            rw_q[i][8*j +: 8] <= wdata[8*j +: 8];
                        end
                    end
                end
            end
        end
    end

    // A clearing write still counts an event landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q <= '0;
        end else if (we && kind == ACC_EVT) begin
            evt_q <= hw_event ? ONE : '0;
        end else if (hw_event && evt_q != '1) begin
            evt_q <= evt_q + ONE;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            kind == ACC_ID:  rdata = DATA_W'(BANK_IDX);
            kind == ACC_EVT: rdata = evt_q;
            default: begin
                for (int i = 0; i < NUM_RW; i++) begin
                    if (int'(addr) == i + 1) begin
                        rdata = rw_q[i];
                    end
                end
            end
        endcase
    end

endmodule

// File: rtl/multi_bank_regfile.sv
// Multi-bank register file: FSM, decode, error logic and read mux.
// Ports: clk, reset, reverse_reset, hw_event[NUM_BANKS], bus (slave modport).
module multi_bank_regfile #(
    parameter int          NUM_BANKS = 1,
    parameter int          NUM_REGS  = 10,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 reverse_reset,
    input  logic [NUM_BANKS-1:0] hw_event,
    multi_bank_regfile_if.slave  bus
);

    import regfile_pkg::*;

    state_e              state_q;
    state_e              state_d;
    logic                ack_q;
    logic                ack_d;
    logic                err_q;
    logic                err_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   rdata_d;
    logic                acc_err;
    logic [NUM_BANKS-1:0] bank_we;
    logic [DATA_W-1:0]   rd_mux;
    logic [DATA_W-1:0]   bank_rdata [NUM_BANKS];

    assign acc_err = (int'(bus.bank) >= NUM_BANKS)
                   || (int'(bus.addr) >= NUM_REGS)
                   || (bus.wr && reg_kind(int'(bus.addr), NUM_REGS) == ACC_ID);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        regfile_bank #(
            .BANK_IDX  (b),
            .NUM_REGS  (NUM_REGS),
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_bank (
            .clk           (clk),
            .reset         (reset),
            .reverse_reset (reverse_reset),
            .we            (bank_we[b]),
            .addr          (bus.addr),
            .wdata         (bus.wdata),
            .be            (bus.be),
            .hw_event      (hw_event[b]),
            .rdata         (bank_rdata[b])
        );
    end

    always_comb begin
        rd_mux = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (int'(bus.bank) == b) begin
                rd_mux = bank_rdata[b];
            end
        end
    end

    // Work happens on acceptance in IDLE; RESP only presents the result.
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = '0;
        bank_we = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = acc_err;
                    if (!acc_err) begin
                        if (bus.wr) begin
                            for (int b = 0; b < NUM_BANKS; b++) begin
                                if (int'(bus.bank) == b) begin
                                    bank_we[b] = 1'b1;
                                end
                            end
                        end else begin
                            rdata_d = rd_mux;
                        end
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_multi_bank_regfile.sv
// Directed bench for multi_bank_regfile: a 5x10x32 instance and a 1x4x8 one.
// Vector table for single accesses plus hand sequences for timing corners.
module tb_multi_bank_regfile;

    logic       clk;
    logic       rst32;
    logic       rev32;
    logic [4:0] hw32;
    logic       rst8;
    logic       rev8;
    logic [0:0] hw8;

    int n_tests;
    int n_fail;

    multi_bank_regfile_if #(.NUM_BANKS(5), .NUM_REGS(10), .DATA_W(32)) bus32 ();
    multi_bank_regfile_if #(.NUM_BANKS(1), .NUM_REGS(4), .DATA_W(8)) bus8 ();

    multi_bank_regfile #(
        .NUM_BANKS (5),
        .NUM_REGS  (10),
        .DATA_W    (32),
        .RESET_VAL (32'hA5A5_0000)
    ) dut32 (
        .clk           (clk),
        .reset         (rst32),
        .reverse_reset (rev32),
        .hw_event      (hw32),
        .bus           (bus32)
    );

    multi_bank_regfile #(
        .NUM_BANKS (1),
        .NUM_REGS  (4),
        .DATA_W    (8),
        .RESET_VAL (32'h1234_5678)
    ) dut8 (
        .clk           (clk),
        .reset         (rst8),
        .reverse_reset (rev8),
        .hw_event      (hw8),
        .bus           (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  bank;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic acc32(input string tag, input logic w, input logic [2:0] b,
                         input logic [3:0] a, input logic [31:0] d,
                         input logic [3:0] e, output logic got_err,
                         output logic [31:0] got_rd);
        @(negedge clk);
        check({tag, "_ack_idle"}, 32'(bus32.ack), 32'd0);
        bus32.req   = 1'b1;
        bus32.wr    = w;
        bus32.bank  = b;
        bus32.addr  = a;
        bus32.wdata = d;
        bus32.be    = e;
        @(posedge clk);
        #1;
        check({tag, "_ack"}, 32'(bus32.ack), 32'd1);
        got_err = bus32.err;
        got_rd  = bus32.rdata;
        @(negedge clk);
        bus32.req = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 32'(bus32.ack), 32'd0);
    endtask

    task automatic acc8(input string tag, input logic w, input logic b,
                        input logic [1:0] a, input logic [7:0] d,
                        input logic e, input logic ev,
                        output logic got_err, output logic [7:0] got_rd);
        @(negedge clk);
        bus8.req   = 1'b1;
        bus8.wr    = w;
        bus8.bank  = b;
        bus8.addr  = a;
        bus8.wdata = d;
        bus8.be    = e;
        hw8        = ev;
        @(posedge clk);
        #1;
        check({tag, "_ack"}, 32'(bus8.ack), 32'd1);
        got_err = bus8.err;
        got_rd  = bus8.rdata;
        @(negedge clk);
        bus8.req = 1'b0;
        hw8      = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 32'(bus8.ack), 32'd0);
    endtask

    task automatic rd32(input string tag, input logic [2:0] b,
                        input logic [3:0] a, input logic [31:0] exp);
        logic        e;
        logic [31:0] r;
        acc32(tag, 1'b0, b, a, 32'h0, 4'h0, e, r);
        check({tag, "_err"}, 32'(e), 32'd0);
        check({tag, "_rdata"}, r, exp);
    endtask

    task automatic rd8(input string tag, input logic [1:0] a,
                       input logic ev, input logic [7:0] exp);
        logic       e;
        logic [7:0] r;
        acc8(tag, 1'b0, 1'b0, a, 8'h0, 1'b0, ev, e, r);
        check({tag, "_err"}, 32'(e), 32'd0);
        check({tag, "_rdata"}, 32'(r), 32'(exp));
    endtask

    initial begin
        logic        e;
        logic [31:0] r;
        logic [7:0]  r8;
        logic [5:0]  pattern;

        n_tests = 0;
        n_fail  = 0;
        rst32 = 1'b1;
        rev32 = 1'b0;
        hw32  = '0;
        rst8  = 1'b1;
        rev8  = 1'b0;
        hw8   = 1'b1;
        bus32.req = 1'b0; bus32.wr = 1'b0; bus32.bank = '0;
        bus32.addr = '0; bus32.wdata = '0; bus32.be = '0;
        bus8.req = 1'b0; bus8.wr = 1'b0; bus8.bank = '0;
        bus8.addr = '0; bus8.wdata = '0; bus8.be = '0;

        vecs.push_back(vec_t'{1'b0, 3'd2, 4'd1, 32'h0, 4'h0, 1'b0, 32'hA5A5_0000});
        vecs.push_back(vec_t'{1'b0, 3'd2, 4'd0, 32'h0, 4'h0, 1'b0, 32'h2});
        vecs.push_back(vec_t'{1'b1, 3'd1, 4'd3, 32'h0, 4'hF, 1'b0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 3'd1, 4'd3, 32'h1122_3344, 4'h5, 1'b0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd1, 4'd3, 32'h0, 4'h0, 1'b0, 32'h0022_0044});
        vecs.push_back(vec_t'{1'b1, 3'd1, 4'd3, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd1, 4'd3, 32'h0, 4'h0, 1'b0, 32'h0022_0044});
        vecs.push_back(vec_t'{1'b0, 3'd5, 4'd1, 32'h0, 4'h0, 1'b1, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd0, 4'd10, 32'h0, 4'h0, 1'b1, 32'h0});
        vecs.push_back(vec_t'{1'b1, 3'd3, 4'd0, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd3, 4'd0, 32'h0, 4'h0, 1'b0, 32'h3});
        vecs.push_back(vec_t'{1'b0, 3'd4, 4'd9, 32'h0, 4'h0, 1'b0, 32'h0});
        vecs.push_back(vec_t'{1'b1, 3'd4, 4'd8, 32'hDEAD_BEEF, 4'hC, 1'b0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd4, 4'd8, 32'h0, 4'h0, 1'b0, 32'hDEAD_0000});
        vecs.push_back(vec_t'{1'b0, 3'd1, 4'd8, 32'h0, 4'h0, 1'b0, 32'hA5A5_0000});
        vecs.push_back(vec_t'{1'b0, 3'd7, 4'd2, 32'h0, 4'h0, 1'b1, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd0, 4'd15, 32'h0, 4'h0, 1'b1, 32'h0});
        vecs.push_back(vec_t'{1'b1, 3'd5, 4'd2, 32'h1234_5678, 4'hF, 1'b1, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd0, 4'd2, 32'h0, 4'h0, 1'b0, 32'hA5A5_0000});
        vecs.push_back(vec_t'{1'b1, 3'd4, 4'd9, 32'h0, 4'h0, 1'b0, 32'h0});
        vecs.push_back(vec_t'{1'b0, 3'd4, 4'd0, 32'h0, 4'h0, 1'b0, 32'h4});

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(bus32.ack), 32'd0);
        check("rst_err", 32'(bus32.err), 32'd0);
        check("rst_rdata", bus32.rdata, 32'h0);
        check("rst8_ack", 32'(bus8.ack), 32'd0);
        @(negedge clk);
        rst32 = 1'b0;
        rst8  = 1'b0;
        hw8   = 1'b0;

        foreach (vecs[i]) begin
            acc32($sformatf("vec%0d", i), vecs[i].wr, vecs[i].bank,
                  vecs[i].addr, vecs[i].wdata, vecs[i].be, e, r);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].err));
            check($sformatf("vec%0d_rdata", i), r, vecs[i].rdata);
        end

        // Reverse reset: RW loads inverted value, EVT and ID unaffected.
        @(negedge clk);
        rst32 = 1'b1;
        rev32 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst32 = 1'b0;
        rev32 = 1'b0;
        rd32("rev_b2a1", 3'd2, 4'd1, 32'h5A5A_FFFF);
        rd32("rev_b2a0", 3'd2, 4'd0, 32'h2);
        rd32("rev_b1a3", 3'd1, 4'd3, 32'h5A5A_FFFF);
        rd32("rev_b2evt", 3'd2, 4'd9, 32'h0);

        // Back-to-back: req held for six cycles.
        @(negedge clk);
        bus32.req  = 1'b1;
        bus32.wr   = 1'b0;
        bus32.bank = 3'd2;
        bus32.addr = 4'd0;
        pattern = '0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            pattern[k] = bus32.ack;
            if (bus32.ack) begin
                check($sformatf("b2b_rdata%0d", k), bus32.rdata, 32'h2);
            end
        end
        @(negedge clk);
        bus32.req = 1'b0;
        check("b2b_pattern", 32'(pattern), 32'h15);
        @(posedge clk);

        // Reset in the RESP cycle of a write.
        @(negedge clk);
        bus32.req   = 1'b1;
        bus32.wr    = 1'b1;
        bus32.bank  = 3'd1;
        bus32.addr  = 4'd3;
        bus32.wdata = 32'h1234_5678;
        bus32.be    = 4'hF;
        @(posedge clk);
        #1;
        check("abort_ack", 32'(bus32.ack), 32'd1);
        @(negedge clk);
        bus32.req = 1'b0;
        rst32     = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ack_gone", 32'(bus32.ack), 32'd0);
        @(negedge clk);
        rst32 = 1'b0;
        rd32("abort_b1a3", 3'd1, 4'd3, 32'hA5A5_0000);

        // Reset in the request cycle: the write never lands.
        @(negedge clk);
        bus32.req   = 1'b1;
        bus32.wr    = 1'b1;
        bus32.bank  = 3'd1;
        bus32.addr  = 4'd4;
        bus32.wdata = 32'h0;
        bus32.be    = 4'hF;
        rst32       = 1'b1;
        @(posedge clk);
        #1;
        check("rstreq_ack", 32'(bus32.ack), 32'd0);
        @(negedge clk);
        bus32.req = 1'b0;
        rst32     = 1'b0;
        rd32("rstreq_b1a4", 3'd1, 4'd4, 32'hA5A5_0000);

        // 8-bit instance: truncated reset value, ID, events ignored in reset.
        rd8("d8_a1", 2'd1, 1'b0, 8'h78);
        rd8("d8_id", 2'd0, 1'b0, 8'h00);
        rd8("d8_evt_rst", 2'd3, 1'b0, 8'h00);
        acc8("d8_wr", 1'b1, 1'b0, 2'd1, 8'hAB, 1'b1, 1'b0, e, r8);
        rd8("d8_a1_ab", 2'd1, 1'b0, 8'hAB);
        acc8("d8_wr_be0", 1'b1, 1'b0, 2'd1, 8'hCD, 1'b0, 1'b0, e, r8);
        check("d8_wr_be0_err", 32'(e), 32'd0);
        rd8("d8_a1_keep", 2'd1, 1'b0, 8'hAB);
        acc8("d8_bank1", 1'b0, 1'b1, 2'd1, 8'h0, 1'b0, 1'b0, e, r8);
        check("d8_bank1_err", 32'(e), 32'd1);
        check("d8_bank1_rdata", 32'(r8), 32'd0);
        acc8("d8_idwr", 1'b1, 1'b0, 2'd0, 8'hFF, 1'b1, 1'b0, e, r8);
        check("d8_idwr_err", 32'(e), 32'd1);

        // 300 event cycles saturate the counter.
        @(negedge clk);
        hw8 = 1'b1;
        repeat (300) @(negedge clk);
        hw8 = 1'b0;
        rd8("d8_evt_sat", 2'd3, 1'b0, 8'hFF);

        // Clearing write with a coincident event leaves 1.
        acc8("d8_evt_clr", 1'b1, 1'b0, 2'd3, 8'h0, 1'b0, 1'b1, e, r8);
        check("d8_evt_clr_err", 32'(e), 32'd0);
        rd8("d8_evt_one", 2'd3, 1'b0, 8'h01);
        rd8("d8_evt_same", 2'd3, 1'b1, 8'h01);
        rd8("d8_evt_two", 2'd3, 1'b0, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
